mux61_tdm_tx: RTL and testbench
===============================

MUX61_TDM_TX -- requirements
Module: mux61_tdm_tx

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of each channel and of the output.

Interface
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port din, input, 6*WIDTH, channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-005 The block SHALL have port in_valid, input, 6, per-channel data-valid.
REQ-006 The block SHALL have port in_ready, output, 6, per-channel accept strobe, at most one bit high.
REQ-007 The block SHALL have port y, output, WIDTH, registered multiplexed data.
REQ-008 The block SHALL have port s, output, 3, registered source-channel index 0..5, the same encoding the 1:6 demux select consumes.
REQ-009 The block SHALL have port out_valid, output, 1, high when y/s hold a transfer.
REQ-010 The block SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-011 Transfers SHALL occur on a channel when in_valid[i] and in_ready[i] are both high at a rising edge; on the output when out_valid and out_ready are both high.
REQ-012 load SHALL be defined as (!out_valid || out_ready); the block SHALL grant only when load is high.
REQ-013 Grant SHALL be round-robin: the first channel with in_valid high, searching ptr, ptr+1, ... modulo 6.
REQ-014 in_ready SHALL be combinational: one-hot on the granted channel when load is high and any in_valid is high; otherwise all zero.
REQ-015 On a grant of channel g, the next edge SHALL register y = din[g], s = g, out_valid = 1, and ptr = (g+1) mod 6 (5 wraps to 0).
REQ-016 When load is high and no in_valid is set, the next edge SHALL clear out_valid; y and s SHALL keep their previous values; ptr SHALL not change.
REQ-017 While out_valid is high and out_ready is low, y, s, out_valid and ptr SHALL hold stable and in_ready SHALL be zero.
REQ-018 Latency SHALL be exactly one clock from channel acceptance to out_valid; sustained throughput SHALL be one transfer per clock when out_ready stays high.
REQ-019 s SHALL never take the values 6 or 7.
REQ-020 in_valid SHALL be sampled only through the grant; a channel dropping in_valid without being granted SHALL lose nothing and SHALL cause no error.

Reset
REQ-021 Assertion of rst_n low SHALL asynchronously force out_valid = 0, y = 0, s = 0 and ptr = 0; in_ready SHALL be zero while in reset.
REQ-022 A transfer pending on the output at reset SHALL be discarded; after deassertion, the first grant SHALL search from channel 0.

Configuration
REQ-023 With macro MUX61_PARITY_EN defined, the block SHALL add output port y_par, 1 bit, the registered even parity (XOR) of the data loaded into y, updated, held and reset to 0 exactly as y is.
REQ-024 Without MUX61_PARITY_EN, port y_par and its logic SHALL be absent, with all other behaviour unchanged.

Verification
REQ-025 Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid, y and s are 0 immediately, with no clock edge required.
REQ-026 Round robin: in_valid=6'b111111, out_ready=1, din[i]=8'h10+i -> s sequence 0,1,2,3,4,5,0 with y=10,11,12,13,14,15,10, one per clock.
REQ-027 Wrap and skip: ptr=5 and in_valid=6'b000101 -> grant channel 0, then channel 2, then channel 0.
REQ-028 Backpressure: out_valid=1 with s=3, out_ready=0 for 4 clocks -> y and s stable, in_ready=0; the next transfer follows one clock after out_ready=1.
REQ-029 Idle: all in_valid=0 after one transfer -> out_valid drops on the next edge with s unchanged.
REQ-030 Parity (MUX61_PARITY_EN): din[1]=8'b0000_0111 granted -> y_par=1; din[1]=8'h03 granted -> y_par=0.

Source files
------------

// File: rtl/mux61_tdm_tx.sv
// mux61_tdm_tx: 6:1 round-robin time-division multiplexer with a registered
// output stage. The output carries the data word and its source-channel
// index s (0..5), which is the same encoding the matching 1:6 demux uses as
// its select.
// The optional y_par output (even parity of y) is built only when the
// macro MUX61_PARITY_EN is defined.
module mux61_tdm_tx #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6*WIDTH-1:0] din,
  input  logic [5:0]         in_valid,
  output logic [5:0]         in_ready,
  output logic [WIDTH-1:0]   y,
  output logic [2:0]         s,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX61_PARITY_EN
  ,
  output logic               y_par
`endif
);

  logic [WIDTH-1:0] chan [6];

  logic [WIDTH-1:0] y_reg, y_next;
  logic [2:0]       s_reg, s_next;
  logic             out_valid_reg, out_valid_next;
  logic [2:0]       ptr_reg, ptr_next;
`ifdef MUX61_PARITY_EN
  logic             y_par_reg, y_par_next;
`endif

  logic             load;
  logic [2:0]       gnt_idx;
  logic             gnt_any;
  logic [3:0]       cand;

  // Split the packed channel bus into one word per channel.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_chan
      assign chan[gi] = din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The output register may be refilled when it is empty or being drained.
  assign load = !out_valid_reg || out_ready;

  // Round-robin search starting at ptr. Scanning from the farthest offset
  // down to offset 0 lets the nearest requesting channel win. ptr is always
  // 0..5, so one conditional subtract is enough for the modulo-6 wrap.
  always_comb begin
    gnt_idx = 3'd0;
    gnt_any = 1'b0;
    cand    = 4'd0;
    for (int k = 5; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + 4'(k);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (in_valid[cand[2:0]]) begin
        gnt_idx = cand[2:0];
        gnt_any = 1'b1;
      end
    end
  end

  // Accept strobe: one-hot on the winner, and only while a load can happen.
  // It is also gated by rst_n so that nothing is accepted while in reset.
  always_comb begin
    in_ready = 6'd0;
    if (rst_n && load && gnt_any) in_ready[gnt_idx] = 1'b1;
  end

  // Next state of the output stage and of the round-robin pointer.
  always_comb begin
    y_next         = y_reg;
    s_next         = s_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
`ifdef MUX61_PARITY_EN
    y_par_next     = y_par_reg;
`endif
    if (load) begin
      if (gnt_any) begin
        y_next         = chan[gnt_idx];
        s_next         = gnt_idx;
        out_valid_next = 1'b1;
        ptr_next       = (gnt_idx == 3'd5) ? 3'd0 : gnt_idx + 3'd1;
`ifdef MUX61_PARITY_EN
        y_par_next     = ^chan[gnt_idx];
`endif
      end else begin
        // Nothing to send: drop valid, but keep y/s and the pointer.
        out_valid_next = 1'b0;
      end
    end
  end

  // State registers. Reset discards any pending output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg         <= '0;
      s_reg         <= 3'd0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= 3'd0;
`ifdef MUX61_PARITY_EN
      y_par_reg     <= 1'b0;
`endif
    end else begin
      y_reg         <= y_next;
      s_reg         <= s_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
`ifdef MUX61_PARITY_EN
      y_par_reg     <= y_par_next;
`endif
    end
  end

  assign y         = y_reg;
  assign s         = s_reg;
  assign out_valid = out_valid_reg;
`ifdef MUX61_PARITY_EN
  assign y_par     = y_par_reg;
`endif

endmodule

// File: tb/tb_mux61_tdm_tx.sv
// Directed self-checking bench for mux61_tdm_tx (WIDTH = 8).
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// there too, well away from the next edge.
module tb_mux61_tdm_tx;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [6*WIDTH-1:0] din;
  logic [5:0]         in_valid;
  logic [5:0]         in_ready;
  logic [WIDTH-1:0]   y;
  logic [2:0]         s;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX61_PARITY_EN
  logic               y_par;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  mux61_tdm_tx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX61_PARITY_EN
    ,
    .y_par     (y_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count it, report a mismatch on one line.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_s;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 6'h3f;
    for (int i = 0; i < 6; i++) din[i*WIDTH +: WIDTH] = 8'(8'h10 + i);

    // Reset state, with requests already present.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y",         32'(y),         32'd0);
    check("rst_s",         32'(s),         32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
`ifdef MUX61_PARITY_EN
    check("rst_y_par",     32'(y_par),     32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'h01);

    // Round robin across all six channels, then wrap back to 0.
    for (int k = 0; k < 7; k++) begin
      step();
      exp_s = k % 6;
      check($sformatf("rr%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("rr%0d_s", k),     32'(s),         32'(exp_s));
      check($sformatf("rr%0d_y", k),     32'(y),         32'(8'h10 + exp_s));
      check($sformatf("rr%0d_ready", k), 32'(in_ready),  32'(6'b1 << ((k + 1) % 6)));
    end

    // Idle: valid drops, s and y are kept. ptr is now 1.
    in_valid = 6'h00;
    #1;
    check("idle_ready", 32'(in_ready), 32'd0);
    step();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_s",     32'(s),         32'd0);
    check("idle_y",     32'(y),         32'h10);

    // Move ptr to 5 by granting channel 4.
    in_valid = 6'b010000;
    step();
    check("pre_wrap_s", 32'(s), 32'd4);

    // Wrap and skip: ptr=5, requests on channels 0 and 2.
    in_valid = 6'b000101;
    #1;
    check("wrap_ready0", 32'(in_ready), 32'b000001);
    step();
    check("wrap_s0",     32'(s),        32'd0);
    check("wrap_y0",     32'(y),        32'h10);
    check("wrap_ready1", 32'(in_ready), 32'b000100);
    step();
    check("wrap_s1",     32'(s),        32'd2);
    check("wrap_y1",     32'(y),        32'h12);
    check("wrap_ready2", 32'(in_ready), 32'b000001);
    step();
    check("wrap_s2",     32'(s),        32'd0);

    // Backpressure: load channel 3, then stall for four clocks.
    in_valid = 6'b001000;
    step();
    check("bp_load_s", 32'(s), 32'd3);
    out_ready = 1'b0;
    in_valid  = 6'h3f;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp%0d_ready", k), 32'(in_ready),  32'd0);
      step();
      check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_s", k),     32'(s),         32'd3);
      check($sformatf("bp%0d_y", k),     32'(y),         32'h13);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b010000);
    step();
    check("bp_next_s", 32'(s), 32'd4);
    check("bp_next_y", 32'(y), 32'h14);

    // Asynchronous reset mid-stream, no edge in between.
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_y",     32'(y),         32'd0);
    check("arst_s",     32'(s),         32'd0);
    check("arst_ready", 32'(in_ready),  32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'b000001);
    step();
    check("post_rst_s", 32'(s), 32'd0);

`ifdef MUX61_PARITY_EN
    // Parity of the loaded word.
    din[1*WIDTH +: WIDTH] = 8'b0000_0111;
    in_valid = 6'b000010;
    step();
    check("par_s1",   32'(s),     32'd1);
    check("par_odd",  32'(y_par), 32'd1);
    din[1*WIDTH +: WIDTH] = 8'h03;
    step();
    check("par_even", 32'(y_par), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
